async_fifo_wptr_ctrl: RTL and testbench
=======================================

Name: async_fifo_wptr_ctrl

Overview:
Write-domain pointer and flag controller for the async FIFO, parametrised in depth. It owns the binary and Gray write pointers and generates the memory write enable and address. It compares the next Gray write pointer against the read pointer already synchronised into the write domain, and produces a registered full flag. It adds behaviour the old combinational full check lacks: registered flags, an occupancy count, a programmable almost-full threshold, and a sticky overflow error.

Parameters:
ADDR_W, 3, FIFO address width; depth DEPTH = 2**ADDR_W; legal range ADDR_W >= 2.
AF_MARGIN, 2, walmost_full asserts when occupancy >= DEPTH - AF_MARGIN; legal range 1..DEPTH-1.

Ports:
wclk  input  1  write-domain clock
wrst_n  input  1  asynchronous active-low reset
winc  input  1  write request from producer
wq2_rptr  input  ADDR_W+1  Gray read pointer, already 2-flop synchronised into wclk
wen  output  1  memory write enable, = winc & ~wfull (combinational)
waddr  output  ADDR_W  memory write address, = wbin[ADDR_W-1:0] (registered)
wptr  output  ADDR_W+1  registered Gray write pointer, sent to the read-domain synchroniser
wfull  output  1  registered full flag
walmost_full  output  1  registered almost-full flag
wcount  output  ADDR_W+1  registered occupancy estimate, 0..DEPTH
woverflow  output  1  sticky error: write attempted while full

Behaviour:
- Reset: asserting wrst_n low clears wbin, wptr, wfull, walmost_full, wcount and woverflow to 0 immediately, with no clock edge required. All outputs return to 0 even mid-burst. Release is synchronous to the next wclk edge in normal use.
- Accept: a write is accepted when wen = 1. The write lands at the current waddr. On that wclk edge, wbin increments by 1, modulo 2**(ADDR_W+1).
- Next-state values, computed every cycle:
  - wbin_next = wbin + wen.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - rbin = Gray-to-binary of wq2_rptr, where bit i is the XOR of wq2_rptr bits ADDR_W down to i.
  - wcount_next = (wbin_next - rbin), modulo 2**(ADDR_W+1).
- Full: wfull_next = (wgray_next == {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]}).
- Almost full: walmost_full_next = (wcount_next >= DEPTH - AF_MARGIN).
- Register update: wptr, wfull, walmost_full and wcount all register their next-state values on every edge. These registered flags already account for a write accepted on that same edge, so latency is zero cycles.
- Full blocks writes: while wfull = 1, wen = 0 regardless of winc. wbin and wptr hold.
- Overflow: winc = 1 while wfull = 1 sets woverflow on that edge. It stays set until reset.
- Pessimism: read-side advances reach this block only through wq2_rptr, so wfull deassertion lags the reads by 2 wclk cycles. wcount may overstate occupancy but never understates it.
- Simultaneous events:
  - Read advance and winc in the same cycle while full: the write is rejected, because wfull is still registered high. wfull falls on that same edge.
  - Read advance and an accepted write in the same cycle: the count is computed net of both.
- Wrap-around: wbin wraps from 2**(ADDR_W+1)-1 to 0 with no special handling. Only one bit of wptr changes per increment, including across the wrap.
- wq2_rptr is trusted as valid Gray code. No checking is performed on it.

Test Plan:
- Reset and defaults: ADDR_W=3, AF_MARGIN=2, pulse wrst_n low -> all outputs 0, waddr=0, wen follows winc.
- Fill: wq2_rptr=0, winc=1 for 8 cycles -> waddr steps 0..7; wptr Gray sequence ends at 4'b1100. walmost_full goes high at the edge where wcount becomes 6. wfull goes high at the edge where wcount becomes 8.
- Overflow: continue winc=1 for 1 more cycle with wfull=1 -> wen=0, wptr stays 4'b1100, wcount stays 8, woverflow=1. woverflow remains 1 after winc drops.
- Drain release: set wq2_rptr=4'b0001 (binary 1) -> next edge wfull=0 and wcount=7. Then winc=1 -> accepted at waddr=0, wfull=1 again.
- Wrap: track wq2_rptr to gray(wbin-2) while writing 40 times -> wbin wraps to 0 twice. Every wptr transition changes exactly one bit. wcount stays 2; wfull and woverflow never assert.
- Async reset mid-burst: at wcount=5, drive wrst_n low between clock edges -> outputs clear before the next edge. After release, writes restart at waddr=0.

Source files
------------

// File: rtl/async_fifo_wptr_ctrl.sv
// Write-domain pointer/flag controller for an async FIFO: binary and Gray write
// pointers, registered full/almost-full flags, occupancy estimate and sticky overflow.
module async_fifo_wptr_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int AF_MARGIN = 2
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              winc,
    input  logic [ADDR_W:0]   wq2_rptr,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wcount,
    output logic              woverflow
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W + 1)'(DEPTH - AF_MARGIN);

    logic [ADDR_W:0] wbin_q, wbin_d;
    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] wcount_q, wcount_d;
    logic            wfull_q, wfull_d;
    logic            walmost_full_q, walmost_full_d;
    logic            woverflow_q, woverflow_d;
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] full_gray;

    // Gated by the registered flag, so a read freeing space this cycle cannot
    // admit a write until the flag itself has dropped.
    assign wen = winc & ~wfull_q;

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign full_gray = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};

    always_comb begin
        wbin_d         = wbin_q + {{ADDR_W{1'b0}}, wen};
        wptr_d         = wbin_d ^ (wbin_d >> 1);
        wcount_d       = wbin_d - rbin;
        wfull_d        = (wptr_d == full_gray);
        walmost_full_d = (wcount_d >= AF_LEVEL);
        woverflow_d    = woverflow_q | (winc & wfull_q);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wcount_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wcount_q       <= wcount_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign waddr        = wbin_q[ADDR_W-1:0];
    assign wptr         = wptr_q;
    assign wcount       = wcount_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_async_fifo_wptr_ctrl.sv
// Self-checking bench for async_fifo_wptr_ctrl against an occupancy-level model
// (write count, read count, occupancy = difference modulo two laps).
module tb_async_fifo_wptr_ctrl;

    localparam int ADDR_W    = 3;
    localparam int AF_MARGIN = 2;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int LAP       = 2 * DEPTH;

    logic              wclk;
    logic              wrst_n;
    logic              winc;
    logic [ADDR_W:0]   wq2_rptr;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W:0]   wptr;
    logic              wfull;
    logic              walmost_full;
    logic [ADDR_W:0]   wcount;
    logic              woverflow;

    async_fifo_wptr_ctrl #(.ADDR_W(ADDR_W), .AF_MARGIN(AF_MARGIN)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull),
        .walmost_full(walmost_full), .wcount(wcount), .woverflow(woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int n_vec = 0;
    int n_err = 0;

    // model: writes and reads counted modulo two laps
    int m_w, m_r, m_occ;
    bit m_full, m_af, m_ovf, m_wen;
    logic obs_wen;

    function automatic logic [ADDR_W:0] gray(input int b);
        logic [ADDR_W:0] x;
        x = b[ADDR_W:0];
        return x ^ (x >> 1);
    endfunction

    function automatic int occ_of(input int w, input int r);
        return (w - r + LAP) % LAP;
    endfunction

    task automatic model_clear();
        m_w = 0; m_r = 0; m_occ = 0;
        m_full = 0; m_af = 0; m_ovf = 0; m_wen = 0;
    endtask

    task automatic do_reset();
        @(negedge wclk);
        winc = 1'b0; wq2_rptr = '0; wrst_n = 1'b0;
        model_clear();
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    // Called at a negedge; leaves time at the following negedge with the model updated.
    task automatic step(input bit inc, input int r);
        winc = inc;
        m_r = r % LAP;
        wq2_rptr = gray(m_r);
        m_wen = inc && !m_full;
        #1;
        obs_wen = wen;
        @(posedge wclk);
        if (m_wen) m_w = (m_w + 1) % LAP;
        if (inc && m_full) m_ovf = 1;
        m_occ  = occ_of(m_w, m_r);
        m_full = (m_occ == DEPTH);
        m_af   = (m_occ >= DEPTH - AF_MARGIN);
        @(negedge wclk);
    endtask

    task automatic test_reset();
        @(negedge wclk);
        winc = 1'b1; wq2_rptr = '0;
        #2 wrst_n = 1'b0;
        #1;
        n_vec++; if ({wptr, wcount, wfull, walmost_full, woverflow} !== '0) begin n_err++; $display("FAIL reset_outputs: got %h exp 0", {wptr, wcount, wfull, walmost_full, woverflow}); end
        n_vec++; if (waddr !== '0) begin n_err++; $display("FAIL reset_waddr: got %0d exp 0", waddr); end
        n_vec++; if (wen !== 1'b1) begin n_err++; $display("FAIL reset_wen_hi: got %b exp 1", wen); end
        winc = 1'b0;
        #1;
        n_vec++; if (wen !== 1'b0) begin n_err++; $display("FAIL reset_wen_lo: got %b exp 0", wen); end
        @(negedge wclk);
        wrst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++; if (waddr !== i[ADDR_W-1:0]) begin n_err++; $display("FAIL fill_waddr: got %0d exp %0d", waddr, i); end
            step(1'b1, 0);
            n_vec++; if (obs_wen !== 1'b1) begin n_err++; $display("FAIL fill_wen: got %b exp 1", obs_wen); end
            n_vec++; if (wcount !== (ADDR_W+1)'(i + 1)) begin n_err++; $display("FAIL fill_wcount: got %0d exp %0d", wcount, i + 1); end
            n_vec++; if (walmost_full !== (i + 1 >= DEPTH - AF_MARGIN)) begin n_err++; $display("FAIL fill_af: got %b at count %0d", walmost_full, i + 1); end
            n_vec++; if (wfull !== (i + 1 == DEPTH)) begin n_err++; $display("FAIL fill_full: got %b at count %0d", wfull, i + 1); end
            n_vec++; if (wptr !== gray(m_w)) begin n_err++; $display("FAIL fill_wptr: got %b exp %b", wptr, gray(m_w)); end
        end
        n_vec++; if (wptr !== 4'b1100) begin n_err++; $display("FAIL fill_wptr_end: got %b exp 1100", wptr); end
    endtask

    task automatic test_overflow();
        step(1'b1, 0);
        n_vec++; if (obs_wen !== 1'b0) begin n_err++; $display("FAIL ovf_wen: got %b exp 0", obs_wen); end
        n_vec++; if (wptr !== 4'b1100) begin n_err++; $display("FAIL ovf_wptr: got %b exp 1100", wptr); end
        n_vec++; if (wcount !== 4'd8) begin n_err++; $display("FAIL ovf_wcount: got %0d exp 8", wcount); end
        n_vec++; if (woverflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b exp 1", woverflow); end
        step(1'b0, 0);
        n_vec++; if (woverflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b exp 1", woverflow); end
    endtask

    task automatic test_drain_release();
        step(1'b0, 1);
        n_vec++; if (wfull !== 1'b0) begin n_err++; $display("FAIL drain_full: got %b exp 0", wfull); end
        n_vec++; if (wcount !== 4'd7) begin n_err++; $display("FAIL drain_wcount: got %0d exp 7", wcount); end
        n_vec++; if (waddr !== 3'd0) begin n_err++; $display("FAIL drain_waddr: got %0d exp 0", waddr); end
        step(1'b1, 1);
        n_vec++; if (obs_wen !== 1'b1) begin n_err++; $display("FAIL drain_wen: got %b exp 1", obs_wen); end
        n_vec++; if (wfull !== 1'b1) begin n_err++; $display("FAIL drain_refull: got %b exp 1", wfull); end
        n_vec++; if (waddr !== 3'd1) begin n_err++; $display("FAIL drain_waddr_next: got %0d exp 1", waddr); end
    endtask

    task automatic test_wrap();
        logic [ADDR_W:0] prev;
        int wraps;
        do_reset();
        step(1'b1, 0);
        step(1'b1, 0);
        wraps = 0;
        prev = wptr;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, (m_w - 1 + LAP) % LAP);
            if (m_w == 0) wraps++;
            n_vec++; if ($countones(wptr ^ prev) != 1) begin n_err++; $display("FAIL wrap_onebit: got %b from %b", wptr, prev); end
            n_vec++; if (wcount !== 4'd2) begin n_err++; $display("FAIL wrap_wcount: got %0d exp 2", wcount); end
            n_vec++; if (wfull !== 1'b0 || woverflow !== 1'b0) begin n_err++; $display("FAIL wrap_flags: got full=%b ovf=%b exp 0/0", wfull, woverflow); end
            n_vec++; if (wptr !== gray(m_w)) begin n_err++; $display("FAIL wrap_wptr: got %b exp %b", wptr, gray(m_w)); end
            prev = wptr;
        end
        n_vec++; if (wraps != 2) begin n_err++; $display("FAIL wrap_count: got %0d exp 2", wraps); end
    endtask

    task automatic test_random();
        int r, occ_now;
        bit inc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            inc = ($urandom_range(0, 3) != 0);
            occ_now = occ_of(m_w, m_r);
            r = m_r;
            if (occ_now > 0 && $urandom_range(0, 2) == 0) r = m_r + $urandom_range(1, occ_now);
            step(inc, r);
            n_vec++; if (obs_wen !== m_wen) begin n_err++; $display("FAIL rnd_wen: got %b exp %b", obs_wen, m_wen); end
            n_vec++; if (waddr !== m_w[ADDR_W-1:0]) begin n_err++; $display("FAIL rnd_waddr: got %0d exp %0d", waddr, m_w % DEPTH); end
            n_vec++; if (wptr !== gray(m_w)) begin n_err++; $display("FAIL rnd_wptr: got %b exp %b", wptr, gray(m_w)); end
            n_vec++; if (wcount !== m_occ[ADDR_W:0]) begin n_err++; $display("FAIL rnd_wcount: got %0d exp %0d", wcount, m_occ); end
            n_vec++; if (wfull !== m_full) begin n_err++; $display("FAIL rnd_full: got %b exp %b", wfull, m_full); end
            n_vec++; if (walmost_full !== m_af) begin n_err++; $display("FAIL rnd_af: got %b exp %b", walmost_full, m_af); end
            n_vec++; if (woverflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf: got %b exp %b", woverflow, m_ovf); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 0);
        n_vec++; if (wcount !== 4'd5) begin n_err++; $display("FAIL areset_pre: got %0d exp 5", wcount); end
        winc = 1'b1;
        #2 wrst_n = 1'b0;
        #1;
        n_vec++; if ({wptr, wcount, wfull, walmost_full, woverflow} !== '0) begin n_err++; $display("FAIL areset_clear: got %h exp 0", {wptr, wcount, wfull, walmost_full, woverflow}); end
        n_vec++; if (waddr !== '0) begin n_err++; $display("FAIL areset_waddr: got %0d exp 0", waddr); end
        @(negedge wclk);
        wrst_n = 1'b1;
        model_clear();
        step(1'b1, 0);
        n_vec++; if (obs_wen !== 1'b1) begin n_err++; $display("FAIL areset_wen: got %b exp 1", obs_wen); end
        n_vec++; if (waddr !== 3'd1 || wcount !== 4'd1) begin n_err++; $display("FAIL areset_restart: got addr=%0d cnt=%0d exp 1/1", waddr, wcount); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wrst_n = 1'b1; winc = 1'b0; wq2_rptr = '0; obs_wen = 1'b0;
        model_clear();
        test_reset();
        test_fill();
        test_overflow();
        test_drain_release();
        test_wrap();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
